// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one pipelined divider among NUM_REQ clients.
// Define DIV_ARB_STATS_EN to add the stat_issue/stat_stall counters.
module div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 8,
  parameter int WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_valid,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic                     rsp_dz,
  output logic                     err_tag
`ifdef DIV_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    stat_issue,
  output logic [15:0]              stat_stall
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WCW = $clog2(LATENCY + 2);

  typedef struct packed {
    logic             vld;
    logic [IDW-1:0]   id;
    logic             dz;
    logic [WIDTH-1:0] dividend;
  } tag_t;

  logic [IDW-1:0]     ptr_q;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW-1:0]     cand;
  logic               found;
  logic               hs;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;

  tag_t               issue_q, issue_d;
  logic               div_start_q;
  logic [WIDTH-1:0]   div_dividend_q, div_divisor_q;
  tag_t               pipe_q [LATENCY+1];
  tag_t               tail;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_quotient_q, rsp_quotient_d;
  logic [WIDTH-1:0]   rsp_remainder_q, rsp_remainder_d;
  logic               rsp_dz_q, rsp_dz_d;
  logic               err_q, err_d;
  logic [WCW-1:0]     warm_q, warm_d;
  logic               warm_done;

  // Search begins just after the last winner; grants are masked while reset is held.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
    if (!reset) grant = '0;
  end

  assign hs        = |grant;
  assign req_ready = grant;

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_dividend = req_dividend[i*WIDTH +: WIDTH];
        sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    issue_d = '0;
    if (hs) begin
      issue_d.vld      = 1'b1;
      issue_d.id       = gnt_idx;
      issue_d.dz       = (sel_divisor == '0);
      issue_d.dividend = sel_dividend;
    end
  end

  // The tag rides in the issue register beside the operands, so the pipe tail meets div_valid.
  assign tail      = pipe_q[LATENCY];
  assign warm_done = (warm_q == WCW'(LATENCY + 1));

  always_comb begin
    rsp_valid_d     = '0;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_dz_d        = rsp_dz_q;
    if (tail.vld) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tail.id == IDW'(i)) rsp_valid_d[i] = 1'b1;
      end
      if (tail.dz) begin
        rsp_quotient_d  = '1;
        rsp_remainder_d = tail.dividend;
        rsp_dz_d        = 1'b1;
      end else begin
        rsp_quotient_d  = div_quotient;
        rsp_remainder_d = div_remainder;
        rsp_dz_d        = 1'b0;
      end
    end
    warm_d = warm_done ? warm_q : warm_q + WCW'(1);
    err_d  = err_q | (warm_done & ((tail.vld & ~tail.dz) != div_valid));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q           <= IDW'(NUM_REQ - 1);
      issue_q         <= '0;
      div_start_q     <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      for (int i = 0; i <= LATENCY; i++) pipe_q[i] <= '0;
      rsp_valid_q     <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_dz_q        <= 1'b0;
      err_q           <= 1'b0;
      warm_q          <= '0;
    end else begin
      if (hs) begin
        ptr_q          <= gnt_idx;
        div_dividend_q <= sel_dividend;
        div_divisor_q  <= sel_divisor;
      end
      div_start_q <= hs && (sel_divisor != '0);
      issue_q     <= issue_d;
      pipe_q[0]   <= issue_q;
      for (int i = 1; i <= LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      rsp_valid_q     <= rsp_valid_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_dz_q        <= rsp_dz_d;
      err_q           <= err_d;
      warm_q          <= warm_d;
    end
  end

  assign div_start     = div_start_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_dz        = rsp_dz_q;
  assign err_tag       = err_q;

`ifdef DIV_ARB_STATS_EN
  logic [15:0] stat_issue_q [NUM_REQ];
  logic [15:0] stat_stall_q;

  // Saturating counters; a stall is any cycle with a valid requester left ungranted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) stat_issue_q[i] <= '0;
      stat_stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && stat_issue_q[i] != 16'hFFFF) stat_issue_q[i] <= stat_issue_q[i] + 16'd1;
      end
      if (|(req_valid & ~grant) && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  always_comb begin
    stat_issue = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_issue[i*16 +: 16] = stat_issue_q[i];
  end
  assign stat_stall = stat_stall_q;
`endif

endmodule
